shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
- Multi-cycle controller for the execute-stage shifter operand.
- Sequences the ARM shift and rotate operations LSL, LSR, ASR, ROR, RRX and rotate-immediate over several cycles, at most STEP bit positions per cycle.
- Produces the operand value and the shifter carry-out.
- Used for register-specified shifts (amount taken from Rs[7:0]), which do not fit the single-cycle path; the execute stage stalls on start_ready/result_valid.

Parameters:
WIDTH, 32, datapath width (fixed at 32 for ARM semantics)
STEP, 4, maximum bit positions shifted per cycle; power of two, 1..32

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous abort of the current operation
start_valid  input  1  request strobe
start_ready  output  1  high only in IDLE
val_in  input  32  value of Rm
imm_mode  input  1  1 = 32-bit immediate form: value {24'b0, imm8}, rotate right by 2*rot4
imm8  input  8  immediate byte
rot4  input  4  immediate rotate field
shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
reg_shift  input  1  1 = amount from register; 0 = 5-bit immediate amount
shift_amt  input  8  amount (Rs[7:0] when reg_shift=1, else low 5 bits used)
carry_in  input  1  current C flag
result_valid  output  1  high in DONE
result_ready  input  1  consumer accepts the result
result  output  32  shifted value
carry_out  output  1  shifter carry-out
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (rst_n low, async):
  - State goes to IDLE.
  - result, carry_out, result_valid and busy are 0; start_ready is 1.
- States:
  - IDLE: accept when start_valid is high. Go to SHIFT if the effective count n > 0, else go to DONE.
  - SHIFT: each cycle, shift by k = min(remaining, STEP) and decrement remaining by k. Go to DONE when remaining reaches 0.
  - DONE: hold result and carry_out stable until result_ready is high, then go to IDLE.
  - A new request is never accepted in the same cycle as the DONE handshake.
- Accept edge:
  - Latch the working register, type, carry = carry_in, and n.
- Effective count n:
  - imm_mode: working value is {24'b0, imm8}, type ROR, n = 2*rot4. With rot4 = 0, carry_out = carry_in.
  - reg_shift with shift_amt = 0: n = 0, value unchanged, carry_out = carry_in.
  - reg_shift, LSL/LSR: n = min(shift_amt, 33). n = 32 gives result 0 with carry = bit0 (LSL) or bit31 (LSR); n = 33 gives 0/0.
  - reg_shift, ASR: n = min(shift_amt, 32).
  - reg_shift, ROR: n = shift_amt mod 32. If n = 0 and shift_amt != 0, the value is unchanged and carry_out = val_in[31].
  - Immediate amount 0:
    - LSL #0: n = 0.
    - LSR #0 and ASR #0: n = 32.
    - ROR #0: RRX, n = 1 single step; result = {carry_in, val[31:1]}, carry_out = val[0].
  - Immediate nonzero amounts: n = amt[4:0].
- Per-step arithmetic:
  - carry_out is the last bit shifted out in that step.
  - LSL/LSR fill with 0; ASR fills with bit31; ROR rotates.
  - An LSL/LSR step may move the full k positions even past bit 31 (33-bit view), so the carry rules above fall out naturally.
- Latency:
  - result_valid rises after 1 + ceil(n/STEP) rising edges, counting the accept edge.
  - Throughput is one operation per (2 + ceil(n/STEP)) cycles under no back-pressure.
- Flush:
  - In SHIFT or DONE, go to IDLE on the next edge and drop result_valid.
  - In IDLE, flush has priority over start_valid; no accept occurs.
- Reset mid-operation: abandons the operation immediately, with the reset values above.
- Inputs are sampled only on the accept edge; changes during SHIFT or DONE are ignored.

Test Plan:
1. LSL reg amt=4, val_in=0x80000001, carry_in=0 -> result=0x00000010, carry_out=0, result_valid after 2 edges.
2. LSR imm amt=0 (means 32), val_in=0x80000000 -> result=0x00000000, carry_out=1, valid after 9 edges (STEP=4). LSL reg amt=200 -> result 0, carry 0.
3. ASR reg amt=40, val_in=0x80000000 -> result=0xFFFFFFFF, carry_out=1, valid after 9 edges.
4. Immediate mode imm8=0xFF, rot4=4 -> result=0xFF000000, carry_out=1, 3 edges. Same with rot4=0, carry_in=1 -> 0x000000FF, carry_out=1, 1 edge.
5. ROR imm #0 (RRX), val_in=0x00000003, carry_in=1 -> 0x80000001, carry_out=1. ROR reg amt=32, val_in=0x80000000 -> unchanged, carry_out=1. Reg amt=0 -> unchanged, carry_out=carry_in.
6. Control checks:
   - result_ready low for 3 cycles in DONE -> result stable, start_ready=0.
   - flush during SHIFT -> IDLE next edge, no result_valid.
   - rst_n pulsed low mid-SHIFT -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle ARM shifter operand sequencer (LSL/LSR/ASR/ROR/RRX, rotate-immediate),
// moving at most STEP bit positions per cycle and producing the shifter carry-out.
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] val_in,
    input  logic             imm_mode,
    input  logic [7:0]       imm8,
    input  logic [3:0]       rot4,
    input  logic [1:0]       shift_type,
    input  logic             reg_shift,
    input  logic [7:0]       shift_amt,
    input  logic             carry_in,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [2:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX} op_t;

    state_t           state, stateNext;
    op_t              op, accOp;
    logic [WIDTH-1:0] work, accWork, stepWork, rorWork;
    logic             carry, accCarry, stepCarry, accept;
    logic [5:0]       remaining, accN, k;
    logic [WIDTH:0]   lslExt, lsrExt, asrExt;

    // Decode the effective count and starting operand for the accept edge.
    always_comb begin
        accWork  = val_in;
        accCarry = carry_in;
        accOp    = op_t'({1'b0, shift_type});
        accN     = '0;
        if (imm_mode) begin
            accWork = WIDTH'(imm8);
            accOp   = OP_ROR;
            accN    = {1'b0, rot4, 1'b0};
        end else if (reg_shift) begin
            if (shift_type == 2'b11) begin
                accN = {1'b0, shift_amt[4:0]};
                if (shift_amt != 8'd0 && shift_amt[4:0] == 5'd0)
                    accCarry = val_in[WIDTH-1];
            end else if (shift_type == 2'b10) begin
                accN = shift_amt > 8'd32 ? 6'd32 : shift_amt[5:0];
            end else begin
                accN = shift_amt > 8'd33 ? 6'd33 : shift_amt[5:0];
            end
        end else begin
            accN = {1'b0, shift_amt[4:0]};
            if (shift_amt[4:0] == 5'd0 && shift_type != 2'b00)
                accN = shift_type == 2'b11 ? 6'd1 : 6'd32;
            if (shift_amt[4:0] == 5'd0 && shift_type == 2'b11)
                accOp = OP_RRX;
        end
    end

    // One step in a 33-bit view, so a full 32-position LSL/LSR leaves the right carry.
    always_comb begin
        k         = remaining > 6'(STEP) ? 6'(STEP) : remaining;
        lslExt    = {1'b0, work} << k;
        lsrExt    = {work, 1'b0} >> k;
        asrExt    = $signed({work, 1'b0}) >>> k;
        rorWork   = (work >> k) | (work << (6'(WIDTH) - k));
        stepWork  = op == OP_LSL ? lslExt[WIDTH-1:0] :
                    op == OP_LSR ? lsrExt[WIDTH:1] :
                    op == OP_ASR ? asrExt[WIDTH:1] :
                    op == OP_ROR ? rorWork : {carry, work[WIDTH-1:1]};
        stepCarry = op == OP_LSL ? lslExt[WIDTH] :
                    op == OP_LSR ? lsrExt[0] :
                    op == OP_ASR ? asrExt[0] :
                    op == OP_ROR ? rorWork[WIDTH-1] : work[0];
    end

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (!flush && start_valid) begin
                accept    = 1'b1;
                stateNext = accN == 6'd0 ? DONE : SHIFT;
            end
            SHIFT: stateNext = flush ? IDLE : remaining == k ? DONE : SHIFT;
            DONE: stateNext = (flush || result_ready) ? IDLE : DONE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= OP_LSL;
            work      <= '0;
            carry     <= 1'b0;
            remaining <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                op        <= accOp;
                work      <= accWork;
                carry     <= accCarry;
                remaining <= accN;
            end else if (state == SHIFT && !flush) begin
                work      <= stepWork;
                carry     <= stepCarry;
                remaining <= remaining - k;
            end
        end
    end

    assign start_ready  = state == IDLE;
    assign result_valid = state == DONE;
    assign busy         = state != IDLE;
    assign result       = work;
    assign carry_out    = carry;
endmodule
